// File: rtl/axi_ram_bridge.sv
// AXI3 slave to synchronous single-port RAM bridge, one transaction at a time.
// Optional feature macro: AXI_RAM_WRAP_BURST_EN enables WRAP burst addressing.
module axi_ram_bridge #(
  parameter int unsigned RAM_AW = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  state_t              state, state_nxt;
  logic                prefer_wr;
  logic [ID_W-1:0]     id_q;
  logic [LEN_W-1:0]    len_q;
  logic [RAM_AW-1:0]   addr_q, addr_nxt, addr_inc;
  logic [LEN_W-1:0]    iss_cnt;
  logic                iss_done;
  logic [LEN_W-1:0]    out_cnt;
  logic                rd_pend;
  logic [1:0]          sk_cnt;
  logic [DATA_W-1:0]   sk0, sk1;
  logic                werr;
  logic [1:0]          bresp_q;

  logic                rd_grant, wr_grant, idle;
  logic                r_pop, sk_pop, sk_push, rd_issue, w_fire, w_last_beat, w_err_now;
  logic [1:0]          inflight;

`ifdef AXI_RAM_WRAP_BURST_EN
  logic [1:0]          burst_q;
  logic [RAM_AW-1:0]   wrap_mask;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache,
                           awprot, wid, araddr, awaddr, arburst, awburst};

  // Round-robin grant only matters when both address channels are valid
  assign idle     = (state == IDLE);
  assign rd_grant = arvalid & (~awvalid | ~prefer_wr);
  assign wr_grant = awvalid & ~rd_grant;
  assign arready  = aresetn & idle & rd_grant;
  assign awready  = aresetn & idle & wr_grant;

  // Read return path: skid buffer head first, otherwise RAM data arriving this cycle
  assign rvalid   = (state == RD) & ((sk_cnt != 2'd0) | rd_pend);
  assign rdata    = (sk_cnt != 2'd0) ? sk0 : ram_rdata;
  assign rlast    = rvalid & (out_cnt == len_q);
  assign rid      = id_q;
  assign rresp    = 2'b00;
  assign r_pop    = rvalid & rready;
  assign sk_pop   = r_pop & (sk_cnt != 2'd0);
  assign sk_push  = rd_pend & ~((sk_cnt == 2'd0) & rready);
  assign inflight = sk_cnt + 2'(rd_pend) - 2'(r_pop);
  assign rd_issue = (state == RD) & ~iss_done & (inflight < 2'd2);

  assign wready      = (state == WR);
  assign w_fire      = wready & wvalid;
  assign w_last_beat = (iss_cnt == len_q);
  assign w_err_now   = wlast ^ w_last_beat;

  assign bvalid = (state == WRESP);
  assign bid    = id_q;
  assign bresp  = bresp_q;

  assign ram_en    = rd_issue | w_fire;
  assign ram_wen   = w_fire ? wstrb : 4'b0000;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata;

  // Next beat address
  always_comb begin
    addr_inc = addr_q + RAM_AW'(1);
    addr_nxt = addr_inc;
`ifdef AXI_RAM_WRAP_BURST_EN
    wrap_mask = RAM_AW'(len_q[3:0]);
    if (burst_q == 2'b10 && (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15))
      addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arready) state_nxt = RD;
               else if (awready) state_nxt = WR;
      RD:      if (r_pop && rlast) state_nxt = IDLE;
      WR:      if (w_fire && w_last_beat) state_nxt = WRESP;
      WRESP:   if (bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prefer_wr <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      iss_cnt   <= '0;
      iss_done  <= 1'b0;
      out_cnt   <= '0;
      rd_pend   <= 1'b0;
      sk_cnt    <= 2'd0;
      werr      <= 1'b0;
      bresp_q   <= 2'b00;
`ifdef AXI_RAM_WRAP_BURST_EN
      burst_q   <= 2'b00;
`endif
    end else begin
      rd_pend <= rd_issue;
      sk_cnt  <= sk_cnt - 2'(sk_pop) + 2'(sk_push);
      if (arready) begin
        prefer_wr <= 1'b1;
        id_q      <= arid;
        len_q     <= arlen;
        addr_q    <= araddr[RAM_AW+1:2];
        iss_cnt   <= '0;
        iss_done  <= 1'b0;
        out_cnt   <= '0;
`ifdef AXI_RAM_WRAP_BURST_EN
        burst_q   <= arburst;
`endif
      end
      if (awready) begin
        prefer_wr <= 1'b0;
        id_q      <= awid;
        len_q     <= awlen;
        addr_q    <= awaddr[RAM_AW+1:2];
        iss_cnt   <= '0;
        werr      <= 1'b0;
`ifdef AXI_RAM_WRAP_BURST_EN
        burst_q   <= awburst;
`endif
      end
      if (rd_issue) begin
        addr_q  <= addr_nxt;
        iss_cnt <= iss_cnt + 8'd1;
        if (iss_cnt == len_q) iss_done <= 1'b1;
      end
      if (r_pop) out_cnt <= out_cnt + 8'd1;
      // Any wlast placement other than exactly the final counted beat is an error
      if (w_fire) begin
        addr_q  <= addr_nxt;
        iss_cnt <= iss_cnt + 8'd1;
        werr    <= werr | w_err_now;
        if (w_last_beat) bresp_q <= (werr | w_err_now) ? 2'b10 : 2'b00;
      end
    end
  end

  // Skid storage carries data only, so it needs no reset
  always_ff @(posedge aclk) begin
    if (sk_pop) sk0 <= sk1;
    if (sk_push) begin
      if ((sk_cnt - 2'(sk_pop)) == 2'd0) sk0 <= ram_rdata;
      else                               sk1 <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_axi_ram_bridge.sv
// Directed bench for axi_ram_bridge: table-driven bursts plus arbitration and reset sequences.
module tb_axi_ram_bridge;

  logic        aclk, aresetn;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [0:65535];
  logic        preload_req;
  logic [31:0] ram_tmp;
  int          wr_count;
  int          checks, errors;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    logic [1:0]  burst;
    logic [15:0] rpat;
    logic [15:0] exp_idx [8];
  } rd_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    logic [7:0]  last_beat;
    logic [1:0]  exp_bresp;
    int          bdelay;
    logic [3:0]  strb [8];
  } wr_vec_t;

  rd_vec_t rd_tab [6];
  wr_vec_t wr_tab [5];
  rd_vec_t arb_rd;
  wr_vec_t arb_wr, rst_wr;

  axi_ram_bridge #(.RAM_AW(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] pat(input logic [15:0] i);
    return {16'hA5C3 ^ i, i};
  endfunction

  function automatic logic [31:0] wd(input logic [3:0] id, input int b);
    return {8'hD0, 4'h0, id, 8'(b), 8'(b) ^ 8'h5A};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Synchronous RAM model: read data appears the cycle after the request
  always @(posedge aclk) begin
    if (preload_req) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
    end else if (ram_en) begin
      if (ram_wen == 4'b0000) begin
        ram_rdata <= mem[ram_addr];
      end else begin
        ram_tmp = mem[ram_addr];
        for (int i = 0; i < 4; i++) if (ram_wen[i]) ram_tmp[8*i +: 8] = ram_wdata[8*i +: 8];
        mem[ram_addr] <= ram_tmp;
      end
    end
  end

  always @(posedge aclk) if (ram_en && ram_wen != 4'b0000) wr_count <= wr_count + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic rd_vec_t mk_rd(input logic [31:0] a, input logic [7:0] l,
      input logic [3:0] id, input logic [1:0] b, input logic [15:0] rp,
      input logic [15:0] e0, input logic [15:0] e1 = 16'h0, input logic [15:0] e2 = 16'h0,
      input logic [15:0] e3 = 16'h0, input logic [15:0] e4 = 16'h0,
      input logic [15:0] e5 = 16'h0, input logic [15:0] e6 = 16'h0,
      input logic [15:0] e7 = 16'h0);
    rd_vec_t v;
    v.addr = a; v.len = l; v.id = id; v.burst = b; v.rpat = rp;
    v.exp_idx[0] = e0; v.exp_idx[1] = e1; v.exp_idx[2] = e2; v.exp_idx[3] = e3;
    v.exp_idx[4] = e4; v.exp_idx[5] = e5; v.exp_idx[6] = e6; v.exp_idx[7] = e7;
    return v;
  endfunction

  function automatic wr_vec_t mk_wr(input logic [31:0] a, input logic [7:0] l,
      input logic [3:0] id, input logic [7:0] lb, input logic [1:0] br, input int bd,
      input logic [3:0] s0 = 4'hF, input logic [3:0] s1 = 4'hF, input logic [3:0] s2 = 4'hF,
      input logic [3:0] s3 = 4'hF);
    wr_vec_t v;
    v.addr = a; v.len = l; v.id = id; v.last_beat = lb; v.exp_bresp = br; v.bdelay = bd;
    v.strb[0] = s0; v.strb[1] = s1; v.strb[2] = s2; v.strb[3] = s3;
    for (int i = 4; i < 8; i++) v.strb[i] = 4'hF;
    return v;
  endfunction

  task automatic drive_ar(input rd_vec_t v);
    araddr = v.addr; arlen = v.len; arid = v.id; arburst = v.burst;
  endtask

  task automatic drive_aw(input wr_vec_t v);
    awaddr = v.addr; awlen = v.len; awid = v.id; awburst = 2'b01;
  endtask

  // Ends at the negedge of the cycle after the AR handshake
  task automatic issue_ar(input rd_vec_t v);
    int n;
    @(negedge aclk);
    drive_ar(v);
    arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); #1; n++; end
    check("ar_ready", 64'(arready), 64'(1));
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic issue_aw(input wr_vec_t v);
    int n;
    @(negedge aclk);
    drive_aw(v);
    awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 20) begin @(negedge aclk); #1; n++; end
    check("aw_ready", 64'(awready), 64'(1));
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic collect_read(input rd_vec_t v);
    int k, cyc;
    logic [15:0] idx;
    k = 0;
    cyc = 0;
    rready = 1'b0;
    #1;
    check("rd_lat_t1", 64'(rvalid), 64'(0));
    @(negedge aclk);
    while (k <= int'(v.len) && cyc < 200) begin
      rready = v.rpat[cyc % 16];
      #1;
      if (cyc == 0) check("rd_lat_t2", 64'(rvalid), 64'(1));
      if (rvalid && k < 8) begin
        idx = v.exp_idx[k];
        check($sformatf("rd_beat%0d", k), 64'({rid, rresp, rlast, rdata}),
              64'({v.id, 2'b00, 1'(k == int'(v.len)), pat(idx)}));
        if (rready) k++;
      end
      cyc++;
      @(negedge aclk);
    end
    rready = 1'b0;
    check("rd_beat_count", 64'(k), 64'(int'(v.len) + 1));
    repeat (3) begin
      #1;
      check("rd_no_extra", 64'(rvalid), 64'(0));
      @(negedge aclk);
    end
  endtask

  task automatic collect_write(input wr_vec_t v);
    int n, start;
    logic [15:0] base, idx;
    start = wr_count;
    base = v.addr[17:2];
    for (int b = 0; b <= int'(v.len); b++) begin
      wvalid = 1'b1;
      wdata  = wd(v.id, b);
      wstrb  = v.strb[b];
      wlast  = (v.last_beat == 8'(b));
      #1;
      if (b == 0) check("wready_t1", 64'(wready), 64'(1));
      n = 0;
      while (!wready && n < 20) begin @(negedge aclk); #1; n++; end
      check($sformatf("wr_ram%0d", b), 64'({ram_en, ram_wen, ram_addr, ram_wdata}),
            64'({1'b1, v.strb[b], 16'(base + 16'(b)), wd(v.id, b)}));
      @(negedge aclk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    #1;
    check("b_resp", 64'({bvalid, bid, bresp}), 64'({1'b1, v.id, v.exp_bresp}));
    repeat (v.bdelay) begin
      @(negedge aclk);
      #1;
      check("b_hold", 64'({bvalid, bid, bresp}), 64'({1'b1, v.id, v.exp_bresp}));
    end
    bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    bready = 1'b0;
    #1;
    check("b_done", 64'(bvalid), 64'(0));
    check("wr_count", 64'(wr_count - start), 64'(int'(v.len) + 1));
    for (int b = 0; b <= int'(v.len); b++) begin
      idx = 16'(base + 16'(b));
      check($sformatf("mem_%0h", idx), 64'(mem[idx]), 64'(merge(pat(idx), wd(v.id, b), v.strb[b])));
    end
    idx = 16'(base + 16'(v.len) + 16'd1);
    check("mem_after", 64'(mem[idx]), 64'(pat(idx)));
  endtask

  initial begin
    int start;
    checks = 0; errors = 0; wr_count = 0;
    preload_req = 1'b1;
    aresetn = 1'b0;
    arid = 4'h0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
    arlock = 2'b11; arcache = 4'hF; arprot = 3'h7;
    awid = 4'h0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
    awlock = 2'b11; awcache = 4'hF; awprot = 3'h7;
    wid = 4'hE; wdata = '0; wstrb = 4'hF; wlast = 1'b0;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;

    rd_tab[0] = mk_rd(32'h0000_0100, 8'd3, 4'h5, 2'b01, 16'hFFFF, 16'h40, 16'h41, 16'h42, 16'h43);
    rd_tab[1] = mk_rd(32'h0000_0100, 8'd3, 4'h9, 2'b01, 16'b0100_1010_0110_1001,
                      16'h40, 16'h41, 16'h42, 16'h43);
`ifdef AXI_RAM_WRAP_BURST_EN
    rd_tab[2] = mk_rd(32'h0000_000C, 8'd3, 4'h3, 2'b10, 16'hFFFF, 16'h3, 16'h0, 16'h1, 16'h2);
`else
    rd_tab[2] = mk_rd(32'h0000_000C, 8'd3, 4'h3, 2'b10, 16'hFFFF, 16'h3, 16'h4, 16'h5, 16'h6);
`endif
    rd_tab[3] = mk_rd(32'h0000_0004, 8'd0, 4'h1, 2'b01, 16'h0006, 16'h1);
    rd_tab[4] = mk_rd(32'hF003_FFF8, 8'd3, 4'hF, 2'b01, 16'h5555, 16'hFFFE, 16'hFFFF, 16'h0, 16'h1);
    rd_tab[5] = mk_rd(32'h0000_1000, 8'd7, 4'h2, 2'b00, 16'h3333, 16'h400, 16'h401, 16'h402,
                      16'h403, 16'h404, 16'h405, 16'h406, 16'h407);

    wr_tab[0] = mk_wr(32'h0000_0200, 8'd1, 4'h6, 8'd1, 2'b00, 3, 4'b0011, 4'b1111);
    wr_tab[1] = mk_wr(32'h0000_0300, 8'd2, 4'h7, 8'd1, 2'b10, 0);
    wr_tab[2] = mk_wr(32'h0000_0400, 8'd0, 4'h8, 8'd0, 2'b00, 1, 4'b0100);
    wr_tab[3] = mk_wr(32'h0000_0500, 8'd1, 4'hA, 8'hFF, 2'b10, 2, 4'b1010, 4'b0101);
    wr_tab[4] = mk_wr(32'h0003_FFFC, 8'd1, 4'hC, 8'd1, 2'b00, 0);

    arb_rd = mk_rd(32'h0000_0020, 8'd0, 4'h4, 2'b01, 16'hFFFF, 16'h8);
    arb_wr = mk_wr(32'h0000_0700, 8'd0, 4'hD, 8'd0, 2'b00, 0);
    rst_wr = mk_wr(32'h0000_0800, 8'd7, 4'h1, 8'd7, 2'b00, 0);

    // Reset state with every valid/ready input held high
    @(negedge aclk);
    preload_req = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    check("reset_outs", 64'({arready, awready, wready, rvalid, rlast, bvalid, ram_en, ram_wen}), 64'(0));
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;

    // Simultaneous requests: read first, then write
    @(negedge aclk);
    drive_ar(arb_rd); drive_aw(arb_wr);
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    check("arb_first", 64'({arready, awready}), 64'(2'b10));
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0; awvalid = 1'b0;
    collect_read(arb_rd);
    @(negedge aclk);
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    check("arb_second", 64'({arready, awready}), 64'(2'b01));
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0; awvalid = 1'b0;
    collect_write(arb_wr);

    for (int i = 0; i < 6; i++) begin
      issue_ar(rd_tab[i]);
      collect_read(rd_tab[i]);
    end
    for (int i = 0; i < 5; i++) begin
      issue_aw(wr_tab[i]);
      collect_write(wr_tab[i]);
    end

    // Reset in the middle of an 8-beat write
    start = wr_count;
    issue_aw(rst_wr);
    for (int b = 0; b < 3; b++) begin
      wvalid = 1'b1; wdata = wd(rst_wr.id, b); wstrb = 4'hF; wlast = 1'b0;
      #1;
      @(negedge aclk);
    end
    wdata = wd(rst_wr.id, 3);
    arvalid = 1'b1; awvalid = 1'b1;
    aresetn = 1'b0;
    #1;
    check("midrst_outs", 64'({arready, awready, wready, rvalid, rlast, bvalid, ram_en, ram_wen}), 64'(0));
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    wvalid = 1'b0; arvalid = 1'b0; awvalid = 1'b0;
    check("midrst_writes", 64'(wr_count - start), 64'(3));
    repeat (6) begin
      @(negedge aclk);
      #1;
      check("midrst_no_resp", 64'({bvalid, wready}), 64'(0));
    end
    check("midrst_mem", 64'(mem[16'h203]), 64'(pat(16'h203)));
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    check("midrst_arb", 64'({arready, awready}), 64'(2'b10));
    arvalid = 1'b0; awvalid = 1'b0;
    @(negedge aclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_ram_bridge.md
AXI_RAM_BRIDGE -- requirements
Module: axi_ram_bridge

Interface
REQ-001 SHALL have parameter RAM_AW, default 16, giving the RAM word-address width (2^RAM_AW 32-bit words).
REQ-002 SHALL have port aclk, input, 1, the single clock; all logic rises on its rising edge.
REQ-003 SHALL have port aresetn, input, 1, reset; asynchronous assert, active-low.
REQ-004 SHALL have AXI3 slave read-address inputs arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0] and arvalid, plus output arready.
REQ-005 SHALL have read-data outputs rid[3:0], rdata[31:0], rresp[1:0], rlast and rvalid, plus input rready.
REQ-006 SHALL have write-address inputs awid[3:0], awaddr[31:0], awlen[7:0], awsize[2:0], awburst[1:0], awlock[1:0], awcache[3:0], awprot[2:0] and awvalid, plus output awready.
REQ-007 SHALL have write-data inputs wid[3:0], wdata[31:0], wstrb[3:0], wlast and wvalid, plus output wready; SHALL have outputs bid[3:0], bresp[1:0] and bvalid, plus input bready.
REQ-008 SHALL have a synchronous single-port RAM master: ram_en (out, 1), ram_wen (out, 4, byte enables), ram_addr (out, RAM_AW, word address), ram_wdata (out, 32), ram_rdata (in, 32); ram_rdata is valid the cycle after ram_en with ram_wen=0.
REQ-009 SHALL ignore arlock, arcache, arprot, awlock, awcache, awprot and wid.

Function
REQ-010 SHALL use an FSM with states IDLE, RD, WR and WRESP, with exactly one transaction outstanding.
REQ-011 In IDLE, arready/awready SHALL be driven combinationally from grant.
  - Both arvalid and awvalid: grant alternates, starting with read after reset.
  - Only one valid: that channel is granted.
REQ-012 An AR handshake at cycle T SHALL latch arid, the address and arlen, and move to RD.
  - First RAM read is issued at T+1; first rvalid appears at T+2.
REQ-013 RD SHALL sustain 1 beat/cycle while rready=1, using a 2-entry skid buffer; a new RAM read is issued only when a skid slot will be free.
  - No beat is dropped or duplicated under any rready pattern.
REQ-014 Read beats SHALL carry rid=latched arid and rresp=2'b00; rlast=1 exactly on beat arlen.
  - FSM returns to IDLE the cycle after the rlast handshake.
REQ-015 An AW handshake at T SHALL move to WR; wready=1 from T+1.
  - Each wvalid&wready beat drives ram_en=1, ram_wen=wstrb, ram_wdata=wdata in that same cycle.
REQ-016 Write burst SHALL end on beat counter == awlen, regardless of wlast.
  - bresp=2'b10 (SLVERR) if wlast was not asserted on exactly that beat; otherwise 2'b00.
REQ-017 In WRESP, bvalid=1 and bid=latched awid SHALL be held until bready; IDLE follows the next cycle.
REQ-018 Word address SHALL be addr[RAM_AW+1:2]; upper and low bits are ignored.
  - Each beat advances the address by one word, wrapping modulo 2^RAM_AW.
  - arsize/awsize are ignored; narrow writes rely on wstrb.
REQ-019 arlen/awlen SHALL support 0..255 (1..256 beats); the beat counter is 8 bits.
REQ-020 ram_en SHALL be 0 whenever no read or write beat is issued.

Reset
REQ-021 While aresetn=0 these outputs SHALL be 0: arready, awready, wready, rvalid, rlast, bvalid, ram_en, ram_wen.
  - FSM is IDLE, skid buffer empty, arbiter points to read.
REQ-022 Reset asserted mid-burst SHALL abandon the transaction immediately; no further RAM writes occur, and no response for it is issued after release.

Configuration
REQ-023 With AXI_RAM_WRAP_BURST_EN defined, arburst/awburst = 2'b10 (WRAP) SHALL wrap the beat address within an aligned (len+1)-word window (len+1 in {2,4,8,16}).
  - Undefined: every burst type SHALL be treated as INCR.

Verification
REQ-024 Write araddr=0x100, arlen=3 after preloading words 0x40..0x43 = A,B,C,D; hold rready=1 -> rvalid at T+2, rdata A,B,C,D on 4 consecutive cycles, rlast on D, rid echoed.
REQ-025 Same read with rready toggling 1,0,0,1,0,1... -> exactly 4 beats, in order, no loss.
REQ-026 awaddr=0x200, awlen=1, wstrb=4'b0011 then 4'b1111, wlast on beat 1 -> RAM words 0x80 and 0x81 updated per strobe; bresp=00; bvalid held until bready.
REQ-027 awlen=2 with wlast on beat 1 -> 3 writes performed, bresp=2'b10.
REQ-028 arvalid and awvalid raised together twice -> read granted first, then write; also: reset asserted mid 8-beat write -> all handshake outputs 0, no bvalid afterwards.
REQ-029 With AXI_RAM_WRAP_BURST_EN, araddr=0x0C, arlen=3, arburst=WRAP -> word order 3,0,1,2; without the macro -> 3,4,5,6.
